// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch front end: PC, one-outstanding word fetch, output reg + 1-entry skid
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic        stall_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic        kill_q,       kill_d;
    logic        req_q,        req_d;
    logic [31:0] addr_q,       addr_d;
    logic        out_valid_q,  out_valid_d;
    logic [31:0] out_pc_q,     out_pc_d;
    logic [31:0] out_inst_q,   out_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] skid_inst_q,  skid_inst_d;

    logic granted;
    logic resp;
    logic accept;
    logic consume;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^branch_addr_i[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        kill_d       = kill_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        granted = (state_q == ST_REQ) && req_q && ibus_gnt_i;
        resp    = (state_q == ST_WAIT) && ibus_rvalid_i;
        accept  = resp && !kill_q && !branch_flag_i;
        consume = out_valid_q && !stall_i;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (granted) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp) begin
                    kill_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (!out_valid_q || consume) begin
                if (skid_valid_q) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = skid_pc_q;
                    out_inst_d  = skid_inst_q;
                    skid_pc_d   = pend_pc_q;
                    skid_inst_d = ibus_rdata_i;
                end else begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pend_pc_q;
                    out_inst_d  = ibus_rdata_i;
                end
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pend_pc_q;
                skid_inst_d  = ibus_rdata_i;
            end
        end else if (consume) begin
            if (skid_valid_q) begin
                out_pc_d     = skid_pc_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
                out_inst_d  = NOP_INST;
            end
        end

        // A redirect wins over everything; an in-flight fetch becomes stale.
        if (branch_flag_i) begin
            pc_d         = {branch_addr_i[31:2], 2'b00};
            out_valid_d  = 1'b0;
            out_inst_d   = NOP_INST;
            skid_valid_d = 1'b0;
            if (granted || ((state_q == ST_WAIT) && !resp)) begin
                kill_d = 1'b1;
            end
        end

        req_d  = (state_d == ST_REQ) && !skid_valid_d;
        addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            kill_q       <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'h0000_0000;
            out_inst_q   <= NOP_INST;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0000_0000;
            skid_inst_q  <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            kill_q       <= kill_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign ibus_req_o  = req_q;
    assign ibus_addr_o = addr_q;
    assign if_valid_o  = out_valid_q;
    assign if_pc_o     = out_pc_q;
    assign if_inst_o   = out_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed cycle-vector bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        stall_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int total;
    int bad;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .stall_i       (stall_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic stall,
                                logic br, logic [31:0] baddr, logic e_req, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t v;
        v.gnt = gnt;     v.rv = rv;         v.rdata = rdata;     v.stall = stall;
        v.br = br;       v.baddr = baddr;   v.e_req = e_req;     v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_outputs(string tag, vec_t v);
        check({tag, " req"}, {31'd0, ibus_req_o}, {31'd0, v.e_req});
        if (v.e_req) check({tag, " addr"}, ibus_addr_o, v.e_addr);
        check({tag, " valid"}, {31'd0, if_valid_o}, {31'd0, v.e_valid});
        if (v.e_valid) check({tag, " pc"}, if_pc_o, v.e_pc);
        check({tag, " inst"}, if_inst_o, v.e_inst);
    endtask

    task automatic apply(string tag, vec_t v);
        @(negedge clk);
        ibus_gnt_i    = v.gnt;
        ibus_rvalid_i = v.rv;
        ibus_rdata_i  = v.rdata;
        stall_i       = v.stall;
        branch_flag_i = v.br;
        branch_addr_i = v.baddr;
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, " req"},   {31'd0, ibus_req_o}, 32'd0);
        check({tag, " addr"},  ibus_addr_o, 32'h0);
        check({tag, " valid"}, {31'd0, if_valid_o}, 32'd0);
        check({tag, " pc"},    if_pc_o, 32'h0);
        check({tag, " inst"},  if_inst_o, NOP);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b0;
        branch_flag_i = 1'b0;
        branch_addr_i = 32'h0;
        stall_i       = 1'b0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;

        // zero-wait fetches of 0, 4, 8
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,  0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0000, 0, 0, 32'h0, 1, 32'h4,  1, 32'h0, 32'hA000_0000));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,  0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0004, 0, 0, 32'h0, 1, 32'h8,  1, 32'h4, 32'hA000_0004));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,  0, 32'h0, NOP));
        // five stalled cycles, two responses fill output and skid
        vecs.push_back(mk(0, 1, 32'hA000_0008, 1, 0, 32'h0, 1, 32'hC,  1, 32'h8, 32'hA000_0008));
        vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,  1, 32'h8, 32'hA000_0008));
        vecs.push_back(mk(0, 1, 32'hA000_000C, 1, 0, 32'h0, 0, 32'h0,  1, 32'h8, 32'hA000_0008));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,  1, 32'h8, 32'hA000_0008));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,  1, 32'h8, 32'hA000_0008));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h10, 1, 32'hC, 32'hA000_000C));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,  0, 32'h0, NOP));
        // redirect to 0x100 while waiting for 0x10
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h100, 0, 32'h0,   0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0010, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0, NOP));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0100, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 32'hA000_0100));
        // redirect to 0x203 in the same cycle as gnt
        vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h203, 0, 32'h0,   0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0104, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0, NOP));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0200, 0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'hA000_0200));
        // address held without gnt, then redirect before gnt to the top word
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h204,       0, 32'h0, NOP));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hAFFF_FFFC, 0, 0, 32'h0,         1, 32'h0, 1, 32'hFFFF_FFFC, 32'hAFFF_FFFC));
        // redirect coinciding with rvalid drops it without setting kill
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h0,  0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0004, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0, NOP));
        vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h0,  0, 32'h0, NOP));
        vecs.push_back(mk(0, 1, 32'hA000_0040, 0, 0, 32'h0,  1, 32'h44, 1, 32'h40, 32'hA000_0040));

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("idle_to_req", mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, NOP));

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // reset while waiting, with a late rvalid across the release
        apply("rst_gnt", mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, NOP));
        @(negedge clk);
        ibus_gnt_i = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = 32'hBAD0_0BAD;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_late_rv", mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, NOP));
        apply("rst_rv_req", mk(0, 1, 32'hBAD0_0BAD, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, NOP));
        apply("rst_gnt0",   mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0, 0, 32'h0, NOP));
        apply("rst_fetch0", mk(0, 1, 32'hA000_0000, 0, 0, 32'h0, 1, 32'h4, 1, 32'h0, 32'hA000_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
